// File: rtl/me_pixel_memory.sv
// -----------------------------------------------------------------------------
// me_pixel_memory
//   Pixel store for the full-search motion estimator. Holds the R_DIM x R_DIM
//   reference block (R) and the S_DIM x S_DIM search window (S), both addressed
//   linearly as row*DIM + col. One registered read port on R and two
//   independent registered read ports on S serve the estimator core. A load
//   port fills either memory before the search starts.
//
// Ports
//   clock      in            rising-edge clock for all logic
//   reset      in            async active-high; clears the read registers only
//   load_en    in            write strobe for the load port
//   load_sel   in            0 = write R, 1 = write S
//   load_addr  in  [S_AW]    linear pixel index (R uses only the low R_AW bits)
//   load_data  in  [DATA_W]  pixel value to store
//   AddressR   in  [R_AW]    R read index
//   AddressS1  in  [S_AW]    S read index, port 1
//   AddressS2  in  [S_AW]    S read index, port 2
//   R          out [DATA_W]  registered R pixel (1-cycle latency)
//   S1         out [DATA_W]  registered S pixel, port 1
//   S2         out [DATA_W]  registered S pixel, port 2
//
// Configuration
//   ME_MEM_RDW_BYPASS_EN  defined  : a read that hits the location written on
//                                    the same edge returns load_data
//                                    (write-first), per port.
//                         undefined: such a read returns the old contents
//                                    (read-first).
// -----------------------------------------------------------------------------
module me_pixel_memory #(
  parameter int DATA_W = 8,
  parameter int R_DIM  = 16,
  parameter int S_DIM  = 31,
  parameter int R_AW   = 8,
  parameter int S_AW   = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic              load_sel,
  input  logic [S_AW-1:0]   load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [R_AW-1:0]   AddressR,
  input  logic [S_AW-1:0]   AddressS1,
  input  logic [S_AW-1:0]   AddressS2,
  output logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] S1,
  output logic [DATA_W-1:0] S2
);

  localparam int R_DEPTH = R_DIM * R_DIM;
  localparam int S_DEPTH = S_DIM * S_DIM;
  localparam logic [S_AW-1:0] S_LIMIT = S_AW'(S_DEPTH);

  logic [DATA_W-1:0] r_mem [R_DEPTH];
  logic [DATA_W-1:0] s_mem [S_DEPTH];

  logic [DATA_W-1:0] r_d,  r_q;
  logic [DATA_W-1:0] s1_d, s1_q;
  logic [DATA_W-1:0] s2_d, s2_q;

  logic [R_AW-1:0] r_wr_addr;
  logic            r_wr;
  logic            s_wr;
  logic            s1_in_range;
  logic            s2_in_range;

  // R has exactly 2**R_AW entries, so the upper load address bits are dropped.
  assign r_wr_addr   = load_addr[R_AW-1:0];
  assign r_wr        = load_en && !load_sel;
  // Writes past the last S pixel are discarded rather than aliased.
  assign s_wr        = load_en && load_sel && (load_addr < S_LIMIT);
  assign s1_in_range = AddressS1 < S_LIMIT;
  assign s2_in_range = AddressS2 < S_LIMIT;

  // NOTE: the pixel arrays have no reset; only the small read registers are
  // cleared, so a mid-run reset preserves stored pixels and maps onto RAM.
  always_ff @(posedge clock) begin
    if (r_wr) begin
      r_mem[r_wr_addr] <= load_data;
    end
    if (s_wr) begin
      s_mem[load_addr] <= load_data;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    r_d  = r_mem[AddressR];
    s1_d = '0;
    s2_d = '0;
    if (s1_in_range) begin
      s1_d = s_mem[AddressS1];
    end
    if (s2_in_range) begin
      s2_d = s_mem[AddressS2];
    end
`ifdef ME_MEM_RDW_BYPASS_EN
    // Write-first: forward the incoming pixel to any port reading the
    // location being written this edge. s_wr already excludes out-of-range
    // writes, so a hit implies an in-range read.
    if (r_wr && (r_wr_addr == AddressR)) begin
      r_d = load_data;
    end
    if (s_wr && (load_addr == AddressS1)) begin
      s1_d = load_data;
    end
    if (s_wr && (load_addr == AddressS2)) begin
      s2_d = load_data;
    end
`endif
  end

  // NOTE: non-blocking assignment for registered state; without the bypass
  // this also yields read-first behaviour, since the array update and the
  // read sample the same pre-edge contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q  <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      r_q  <= r_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign R  = r_q;
  assign S1 = s1_q;
  assign S2 = s2_q;

endmodule

// File: tb/tb_me_pixel_memory.sv
// -----------------------------------------------------------------------------
// tb_me_pixel_memory
//   Self-checking bench for me_pixel_memory. Inputs change on the falling
//   edge; each driven cycle may push one expected-result entry which a monitor
//   pops and compares 1 ns after the following rising edge. Expected pixels
//   come from a bench-side copy of both memories updated as loads are driven.
// -----------------------------------------------------------------------------
module tb_me_pixel_memory;

  localparam int R_DEPTH = 256;
  localparam int S_DEPTH = 961;

  logic       clock;
  logic       reset;
  logic       load_en;
  logic       load_sel;
  logic [9:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] AddressR;
  logic [9:0] AddressS1;
  logic [9:0] AddressS2;
  logic [7:0] R;
  logic [7:0] S1;
  logic [7:0] S2;

  me_pixel_memory dut (
    .clock     (clock),
    .reset     (reset),
    .load_en   (load_en),
    .load_sel  (load_sel),
    .load_addr (load_addr),
    .load_data (load_data),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .R         (R),
    .S1        (S1),
    .S2        (S2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef ME_MEM_RDW_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    string      tag;
    bit         chk_r;
    bit         chk_s1;
    bit         chk_s2;
    logic [7:0] r;
    logic [7:0] s1;
    logic [7:0] s2;
  } exp_t;

  exp_t sb[$];

  logic [7:0] r_model [R_DEPTH];
  logic [7:0] s_model [S_DEPTH];

  int checks = 0;
  int errors = 0;

  // Monitor: one entry at most is outstanding, pushed before an edge and
  // compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_r) begin
          checks++;
          if (R !== e.r) begin
            errors++;
            $display("FAIL %s R: got %h expected %h", e.tag, R, e.r);
          end
        end
        if (e.chk_s1) begin
          checks++;
          if (S1 !== e.s1) begin
            errors++;
            $display("FAIL %s S1: got %h expected %h", e.tag, S1, e.s1);
          end
        end
        if (e.chk_s2) begin
          checks++;
          if (S2 !== e.s2) begin
            errors++;
            $display("FAIL %s S2: got %h expected %h", e.tag, S2, e.s2);
          end
        end
      end
    end
  end

  // Drive one cycle of stimulus, derive the expected read data from the
  // bench model (honouring the read-during-write mode), then update the model.
  task automatic cycle(input bit le, input bit sel, input logic [9:0] la,
                       input logic [7:0] ld, input logic [7:0] ar,
                       input logic [9:0] as1, input logic [9:0] as2,
                       input bit cr, input bit cs1, input bit cs2,
                       input string tag);
    exp_t e;
    bit   s_wr;
    @(negedge clock);
    load_en   = le;
    load_sel  = sel;
    load_addr = la;
    load_data = ld;
    AddressR  = ar;
    AddressS1 = as1;
    AddressS2 = as2;
    s_wr      = le && sel && (la < 10'(S_DEPTH));
    e.tag     = tag;
    e.chk_r   = cr;
    e.chk_s1  = cs1;
    e.chk_s2  = cs2;
    e.r  = (BYPASS && le && !sel && (la[7:0] == ar)) ? ld : r_model[ar];
    e.s1 = (as1 >= 10'(S_DEPTH)) ? 8'h00 :
           (BYPASS && s_wr && (la == as1)) ? ld : s_model[as1];
    e.s2 = (as2 >= 10'(S_DEPTH)) ? 8'h00 :
           (BYPASS && s_wr && (la == as2)) ? ld : s_model[as2];
    if (cr || cs1 || cs2) sb.push_back(e);
    if (le && !sel) r_model[la[7:0]] = ld;
    if (s_wr) s_model[la] = ld;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({R, S1, S2} !== 24'h0) begin
      errors++;
      $display("FAIL %s: got R=%h S1=%h S2=%h expected all 00", tag, R, S1, S2);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    load_en   = 1'b0;
    load_sel  = 1'b0;
    load_addr = '0;
    load_data = '0;
    AddressR  = '0;
    AddressS1 = '0;
    AddressS2 = '0;
    #1;
    check_zero("reset_asserted");
    @(posedge clock);
    #1;
    check_zero("reset_held_edge");
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_zero("reset_released");
  endtask

  task automatic test_load_r();
    for (int i = 0; i < R_DEPTH; i++)
      cycle(1'b1, 1'b0, 10'(i), 8'(i), 8'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "load_r");
    cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'h25, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, "r_read_25");
    for (int i = 0; i < R_DEPTH; i++)
      cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'(i), 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, "r_sweep");
  endtask

  task automatic test_load_s();
    for (int i = 0; i < S_DEPTH; i++)
      cycle(1'b1, 1'b1, 10'(i), 8'(i) ^ 8'h5A, 8'd0, 10'd0, 10'd0,
            1'b0, 1'b0, 1'b0, "load_s");
    cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'd0, 10'd0, 10'd960, 1'b0, 1'b1, 1'b1, "s_corners");
    for (int i = 0; i < 16; i++) begin
      logic [9:0] a;
      a = 10'($urandom_range(0, S_DEPTH - 1));
      cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'd0, a, a, 1'b0, 1'b1, 1'b1, "s_same_addr");
    end
  endtask

  task automatic test_out_of_range();
    cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'd0, 10'd961, 10'd1023, 1'b0, 1'b1, 1'b1, "s_oor_read");
    cycle(1'b1, 1'b1, 10'd1000, 8'hFF, 8'd0, 10'd961, 10'd1000, 1'b0, 1'b1, 1'b1,
          "s_oor_write");
    // Every stored S pixel must be unchanged by the dropped write.
    for (int i = 0; i <= 480; i++)
      cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'd0, 10'(i), 10'(960 - i), 1'b0, 1'b1, 1'b1,
            "s_oor_scan");
  endtask

  task automatic test_r_upper_bits();
    cycle(1'b1, 1'b0, 10'h305, 8'h77, 8'h00, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "r_upper_wr");
    cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'h05, 10'h305, 10'd0, 1'b1, 1'b1, 1'b0, "r_upper_rd");
    cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'h06, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, "r_upper_nbr");
  endtask

  task automatic test_rdw();
    cycle(1'b1, 1'b1, 10'd100, 8'h11, 8'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "rdw_prep");
    cycle(1'b1, 1'b1, 10'd100, 8'hEE, 8'd0, 10'd100, 10'd101, 1'b0, 1'b1, 1'b1, "rdw_s1");
    cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'd0, 10'd100, 10'd100, 1'b0, 1'b1, 1'b1, "rdw_s_after");
    cycle(1'b1, 1'b1, 10'd200, 8'hC3, 8'd0, 10'd199, 10'd200, 1'b0, 1'b1, 1'b1, "rdw_s2");
    cycle(1'b1, 1'b0, 10'd7, 8'h33, 8'd7, 10'd200, 10'd0, 1'b1, 1'b1, 1'b0, "rdw_r");
    cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'd7, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, "rdw_r_after");
  endtask

  task automatic test_reset_mid_run();
    cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'h25, 10'd0, 10'd960, 1'b1, 1'b1, 1'b1, "pre_reset");
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_zero("mid_reset_async");
    @(posedge clock);
    #1;
    check_zero("mid_reset_edge");
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_zero("mid_reset_release");
    // Inputs still present the pre-reset addresses; contents must survive.
    cycle(1'b0, 1'b0, 10'd0, 8'd0, 8'h25, 10'd0, 10'd960, 1'b1, 1'b1, 1'b1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_load_r();
    test_load_s();
    test_out_of_range();
    test_r_upper_bits();
    test_rdw();
    test_reset_mid_run();
    idle();
    idle();
    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
